inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Streams instruction words from a valid/ready source into an on-chip memory
// through an Avalon-MM master port. Each load writes `length` consecutive
// words starting at `base_addr`, wrapping at the top of the address space,
// and keeps a running 32-bit checksum of every word written.
//
// Optional feature (compile-time macro INST_LOADER_VERIFY_EN):
//   When defined, every load is followed by a readback pass that re-reads all
//   written words, sums them and raises `error` if that sum differs from the
//   write checksum. When undefined, the load finishes straight after the last
//   write and `error` is tied low.
//
// Ports
//   clk          single clock
//   reset_n      synchronous active-low reset
//   start        one-cycle load request, honoured only while idle
//   base_addr    first word address, captured on an accepted start
//   length       word count 0..2^ADDR_W, captured on an accepted start
//   in_data      streamed instruction word
//   in_valid     in_data is valid
//   in_ready     word accepted when in_valid and in_ready are both high
//   address      Avalon-MM word address
//   chipselect   Avalon-MM access strobe
//   write        Avalon-MM write strobe
//   byteenable   all ones during any access
//   writedata    Avalon-MM write data
//   readdata     slave read data, valid one cycle after a read strobe
//   waitrequest  slave stall
//   busy         high whenever a load is in progress
//   done         one-cycle completion pulse
//   error        readback mismatch flag, held until the next accepted start
//   checksum     modulo-2^32 sum of all written words
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     address,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W-1:0]     readdata,
    input  logic                  waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef INST_LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_DONE    = 3'd4
    } state_t;
`endif

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   idx_inc;
    logic              last_word;
    logic              wr_fire;
    logic [31:0]       checksum_q;
    logic [31:0]       in_word32;

    // The checksum is always 32 bits wide; narrower data is zero-extended and
    // wider data contributes only its low 32 bits.
    generate
        if (DATA_W >= 32) begin : g_in_wide
            assign in_word32 = in_data[31:0];
        end else begin : g_in_narrow
            assign in_word32 = {{(32-DATA_W){1'b0}}, in_data};
        end
    endgenerate

    assign idx_inc   = idx_q + IDX_ONE;
    assign last_word = (idx_inc == len_q);

    // Word address wraps naturally at 2^ADDR_W because the sum is truncated.
    assign address  = base_q + idx_q[ADDR_W-1:0];
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign checksum = checksum_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus strobes. Write strobes follow in_valid combinationally
    // so a continuous stream retires one word per cycle.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        byteenable = '0;
        writedata  = '0;
        wr_fire    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                in_ready = ~waitrequest;
                if (in_valid) begin
                    chipselect = 1'b1;
                    write      = 1'b1;
                    byteenable = {BE_W{1'b1}};
                    writedata  = in_data;
                    if (!waitrequest) begin
                        wr_fire = 1'b1;
                        if (last_word) begin
`ifdef INST_LOADER_VERIFY_EN
                            state_next = ST_RD_REQ;
`else
                            state_next = ST_DONE;
`endif
                        end
                    end
                end
            end

`ifdef INST_LOADER_VERIFY_EN
            ST_RD_REQ: begin
                chipselect = 1'b1;
                byteenable = {BE_W{1'b1}};
                if (!waitrequest) begin
                    state_next = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (last_word) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RD_REQ;
                end
            end
`endif

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef INST_LOADER_VERIFY_EN
    logic [31:0] verify_sum_q;
    logic [31:0] rd_word32;
    logic [31:0] verify_sum_next;
    logic        error_q;

    generate
        if (DATA_W >= 32) begin : g_rd_wide
            assign rd_word32 = readdata[31:0];
        end else begin : g_rd_narrow
            assign rd_word32 = {{(32-DATA_W){1'b0}}, readdata};
        end
    endgenerate

    assign verify_sum_next = verify_sum_q + rd_word32;
    assign error           = error_q;

    // Load datapath with readback. The word index is reused for the read pass,
    // so it restarts from zero once the last write retires.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            checksum_q   <= '0;
            verify_sum_q <= '0;
            error_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q       <= base_addr;
                        len_q        <= length;
                        idx_q        <= '0;
                        checksum_q   <= '0;
                        verify_sum_q <= '0;
                        error_q      <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_fire) begin
                        checksum_q <= checksum_q + in_word32;
                        if (last_word) begin
                            idx_q <= '0;
                        end else begin
                            idx_q <= idx_inc;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    verify_sum_q <= verify_sum_next;
                    idx_q        <= idx_inc;
                    if (last_word) begin
                        error_q <= (verify_sum_next != checksum_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic unused_readdata;

    // Without readback the slave's read data has no consumer.
    assign unused_readdata = ^readdata;
    assign error           = 1'b0;

    // Load datapath: capture the job, then advance the index and accumulate
    // the checksum on every retired write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            checksum_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        len_q      <= length;
                        idx_q      <= '0;
                        checksum_q <= '0;
                    end
                end
                ST_WRITE: begin
                    if (wr_fire) begin
                        checksum_q <= checksum_q + in_word32;
                        idx_q      <= idx_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Directed testbench for inst_mem_loader with a small Avalon-MM memory model
// that honours waitrequest and returns read data one cycle after a read strobe.
// Build with INST_LOADER_VERIFY_EN defined to exercise the readback pass.
// -----------------------------------------------------------------------------
module tb_inst_mem_loader;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
`ifdef INST_LOADER_VERIFY_EN
    localparam int VERIFY_ON = 1;
`else
    localparam int VERIFY_ON = 0;
`endif

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     length;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata = '0;
    logic                waitrequest;
    logic                busy;
    logic                done;
    logic                error;
    logic [31:0]         checksum;

    int checks = 0;
    int errors = 0;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    int                wr_count   = 0;
    int                cs_count   = 0;
    int                done_count = 0;
    logic              corrupt_en = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '0;

    inst_mem_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .byteenable (byteenable),
        .writedata  (writedata),
        .readdata   (readdata),
        .waitrequest(waitrequest),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave model plus event counters for bus activity and done pulses.
    always @(posedge clk) begin
        if (done === 1'b1) done_count <= done_count + 1;
        if (chipselect === 1'b1) cs_count <= cs_count + 1;
        if (chipselect === 1'b1 && waitrequest == 1'b0) begin
            if (write) begin
                mem[address] <= writedata;
                wr_count     <= wr_count + 1;
            end else begin
                readdata <= mem[address] ^ ((corrupt_en && address == corrupt_addr) ? 32'h1 : 32'h0);
            end
        end
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start; returns one cycle later with start low.
    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        tick();
        start = 1'b0;
    endtask

    // Present one word with no stall, check the strobes, then let it retire.
    task automatic writeWord(input string tag, input logic [31:0] d, input logic [ADDR_W-1:0] exp_addr);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        checkOutput({tag, "_addr"}, address, exp_addr);
        checkOutput({tag, "_cs"}, chipselect, 1'b1);
        checkOutput({tag, "_wr"}, write, 1'b1);
        checkOutput({tag, "_be"}, byteenable, 4'hF);
        checkOutput({tag, "_wdata"}, writedata, d);
        checkOutput({tag, "_ready"}, in_ready, 1'b1);
        tick();
    endtask

    task automatic waitDone(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    int n;
    int wr0;
    int cs0;
    int dn0;

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        length      = '0;
        in_data     = '0;
        in_valid    = 1'b0;
        waitrequest = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_cs", chipselect, 1'b0);
        checkOutput("rst_write", write, 1'b0);
        checkOutput("rst_ready", in_ready, 1'b0);
        checkOutput("rst_checksum", checksum, 32'h0);
        checkOutput("rst_address", address, 14'h0);
        reset_n = 1'b1;
        tick();

        $display("[TB] basic load of four words");
        wr0 = wr_count;
        applyStimulus(14'h0010, 15'd4);
        checkOutput("t1_busy", busy, 1'b1);
        writeWord("t1_w0", 32'd1, 14'h0010);
        writeWord("t1_w1", 32'd2, 14'h0011);
        writeWord("t1_w2", 32'd3, 14'h0012);
        writeWord("t1_w3", 32'd4, 14'h0013);
        in_valid = 1'b0;
        waitDone(40, n);
        checkOutput("t1_done_latency", n, 8 * VERIFY_ON);
        checkOutput("t1_done", done, 1'b1);
        checkOutput("t1_checksum", checksum, 32'h0000000A);
        checkOutput("t1_error", error, 1'b0);
        checkOutput("t1_writes", wr_count - wr0, 4);
        checkOutput("t1_mem10", mem[14'h0010], 32'd1);
        checkOutput("t1_mem13", mem[14'h0013], 32'd4);
        tick();
        checkOutput("t1_done_clear", done, 1'b0);
        checkOutput("t1_idle", busy, 1'b0);

        $display("[TB] address wrap at top of memory");
        applyStimulus(14'h3FFE, 15'd3);
        writeWord("t2_w0", 32'h0000000A, 14'h3FFE);
        writeWord("t2_w1", 32'h0000000B, 14'h3FFF);
        writeWord("t2_w2", 32'h0000000C, 14'h0000);
        in_valid = 1'b0;
        waitDone(40, n);
        checkOutput("t2_done", done, 1'b1);
        checkOutput("t2_checksum", checksum, 32'h00000021);
        checkOutput("t2_error", error, 1'b0);
        checkOutput("t2_mem0", mem[14'h0000], 32'h0000000C);
        tick();

        $display("[TB] zero-length load");
        cs0 = cs_count;
        applyStimulus(14'h0050, 15'd0);
        checkOutput("t3_done", done, 1'b1);
        checkOutput("t3_busy", busy, 1'b1);
        checkOutput("t3_cs", chipselect, 1'b0);
        checkOutput("t3_checksum", checksum, 32'h0);
        tick();
        checkOutput("t3_done_clear", done, 1'b0);
        checkOutput("t3_no_access", cs_count - cs0, 0);

        $display("[TB] gaps, stalls and ignored start");
        wr0 = wr_count;
        applyStimulus(14'h0100, 15'd4);
        writeWord("t4_w0", 32'h11, 14'h0100);
        in_valid  = 1'b0;
        start     = 1'b1;
        base_addr = 14'h3000;
        length    = 15'd1;
        #1;
        checkOutput("t4_gap_cs", chipselect, 1'b0);
        checkOutput("t4_gap_ready", in_ready, 1'b1);
        tick();
        start       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'h22;
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t4_stall_ready", in_ready, 1'b0);
            checkOutput("t4_stall_cs", chipselect, 1'b1);
            checkOutput("t4_stall_wr", write, 1'b1);
            checkOutput("t4_stall_addr", address, 14'h0101);
            checkOutput("t4_stall_wdata", writedata, 32'h22);
            tick();
        end
        checkOutput("t4_stall_checksum", checksum, 32'h11);
        waitrequest = 1'b0;
        writeWord("t4_w1", 32'h22, 14'h0101);
        writeWord("t4_w2", 32'h33, 14'h0102);
        in_valid = 1'b0;
        tick();
        writeWord("t4_w3", 32'h44, 14'h0103);
        in_valid = 1'b0;
        waitDone(40, n);
        checkOutput("t4_done", done, 1'b1);
        checkOutput("t4_checksum", checksum, 32'h000000AA);
        checkOutput("t4_writes", wr_count - wr0, 4);
        checkOutput("t4_mem101", mem[14'h0101], 32'h22);
        checkOutput("t4_mem103", mem[14'h0103], 32'h44);
        tick();

        $display("[TB] reset in the middle of a load");
        wr0 = wr_count;
        dn0 = done_count;
        applyStimulus(14'h0200, 15'd8);
        writeWord("t5_w0", 32'd1, 14'h0200);
        writeWord("t5_w1", 32'd2, 14'h0201);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_cs", chipselect, 1'b0);
        checkOutput("t5_done", done, 1'b0);
        checkOutput("t5_checksum", checksum, 32'h0);
        in_valid = 1'b1;
        in_data  = 32'd3;
        #1;
        checkOutput("t5_cs_held", chipselect, 1'b0);
        checkOutput("t5_ready_held", in_ready, 1'b0);
        tick();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        tick();
        checkOutput("t5_writes", wr_count - wr0, 2);
        checkOutput("t5_no_done", done_count - dn0, 0);
        applyStimulus(14'h0300, 15'd2);
        writeWord("t5_r0", 32'd5, 14'h0300);
        writeWord("t5_r1", 32'd6, 14'h0301);
        in_valid = 1'b0;
        waitDone(40, n);
        checkOutput("t5_restart_done", done, 1'b1);
        checkOutput("t5_restart_checksum", checksum, 32'h0000000B);
        tick();

`ifdef INST_LOADER_VERIFY_EN
        $display("[TB] readback with a corrupted word");
        corrupt_en   = 1'b1;
        corrupt_addr = 14'h0022;
        applyStimulus(14'h0020, 15'd4);
        writeWord("t6_w0", 32'd1, 14'h0020);
        writeWord("t6_w1", 32'd2, 14'h0021);
        writeWord("t6_w2", 32'd3, 14'h0022);
        writeWord("t6_w3", 32'd4, 14'h0023);
        in_valid = 1'b0;
        waitDone(40, n);
        checkOutput("t6_verify_cycles", n, 8);
        checkOutput("t6_done", done, 1'b1);
        checkOutput("t6_error", error, 1'b1);
        tick();
        checkOutput("t6_error_hold", error, 1'b1);
        corrupt_en = 1'b0;
        applyStimulus(14'h0040, 15'd0);
        checkOutput("t6_error_cleared", error, 1'b0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
